// File: rtl/rst_pkg.sv
// Shared types for the reset sequencer: FSM states, reset-cause codes and the
// per-state domain mask used by rst_seq_gen and rst_wdt_cnt.
package rst_pkg;

  localparam int unsigned PHASE_W = 8;
  localparam int unsigned WDT_W   = 16;
  localparam int unsigned NUM_DOM = 3;

  typedef enum logic [2:0] {
    ST_HOLD = 3'd0,
    ST_REL0 = 3'd1,
    ST_REL1 = 3'd2,
    ST_REL2 = 3'd3,
    ST_RUN  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'd0,
    CAUSE_SW   = 2'd1,
    CAUSE_WDT  = 2'd2,
    CAUSE_RSVD = 2'd3
  } cause_e;

  // Domains still held in reset while the sequencer sits in a given state.
  function automatic logic [NUM_DOM-1:0] dom_mask(input state_e st);
    logic [NUM_DOM-1:0] m;
    case (st)
      ST_HOLD, ST_REL0: m = 3'b111;
      ST_REL1:          m = 3'b110;
      ST_REL2:          m = 3'b100;
      default:          m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/rst_seq_gen_if.sv
// Request/status bundle between the reset sequencer and its controller.
// slave = sequencer side, master = requester/observer side.
interface rst_seq_gen_if;
  import rst_pkg::*;

  logic                swrst_req;
  logic                wdt_en;
  logic                wdt_kick;
  logic                orst_;
  logic [NUM_DOM-1:0]  rstmsk;
  cause_e              rst_cause;
  logic                busy;

  modport master (
    output swrst_req, wdt_en, wdt_kick,
    input  orst_, rstmsk, rst_cause, busy
  );

  modport slave (
    input  swrst_req, wdt_en, wdt_kick,
    output orst_, rstmsk, rst_cause, busy
  );

endinterface

// File: rtl/rst_wdt_cnt.sv
// Watchdog counter for the reset sequencer: counts RUN cycles while enabled and
// flags expiry combinationally when the terminal count is held without a kick.
module rst_wdt_cnt
  import rst_pkg::*;
#(
  parameter int unsigned WDT_LIMIT = 65535
) (
  input  logic clk,
  input  logic rst_,
  input  logic run,
  input  logic wdt_en,
  input  logic wdt_kick,
  output logic expire_c
);

  localparam logic [WDT_W-1:0] LIMIT = WDT_W'(WDT_LIMIT);

  logic [WDT_W-1:0] cnt_q, cnt_d;
  logic             counting_c;

  // A kick in the expiry cycle suppresses the expiry.
  assign counting_c = run & wdt_en & ~wdt_kick;
  assign expire_c   = counting_c & (cnt_q == LIMIT);

  always_comb begin
    cnt_d = '0;
    if (counting_c && !expire_c) begin
      cnt_d = cnt_q + WDT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rst_seq_gen.sv
// Reset sequencer: holds orst_ low, then releases three reset domains in turn.
// Optional watchdog enabled by defining RST_SEQ_GEN_WDT_EN.
module rst_seq_gen
  import rst_pkg::*;
#(
  parameter int unsigned HOLD_CYC  = 16,
  parameter int unsigned STAGE_CYC = 4,
  parameter int unsigned WDT_LIMIT = 65535
) (
  input  logic          clk,
  input  logic          rst_,
  rst_seq_gen_if.slave  bus
);

  localparam logic [PHASE_W-1:0] HOLD_LAST  = PHASE_W'(HOLD_CYC - 1);
  localparam logic [PHASE_W-1:0] STAGE_LAST = PHASE_W'(STAGE_CYC - 1);

  state_e              state_q, state_d;
  logic [PHASE_W-1:0]  cnt_q, cnt_d;
  cause_e              cause_q, cause_d;
  logic                orst_q, orst_d;
  logic [NUM_DOM-1:0]  rstmsk_q, rstmsk_d;
  logic                busy_q, busy_d;
  logic                wdt_exp_c;

`ifdef RST_SEQ_GEN_WDT_EN
  logic in_run_c;

  assign in_run_c = (state_q == ST_RUN);

  rst_wdt_cnt #(
    .WDT_LIMIT (WDT_LIMIT)
  ) u_wdt (
    .clk      (clk),
    .rst_     (rst_),
    .run      (in_run_c),
    .wdt_en   (bus.wdt_en),
    .wdt_kick (bus.wdt_kick),
    .expire_c (wdt_exp_c)
  );
`else
  // Watchdog inputs are accepted but have no effect in this build.
  logic unused_wdt;
  assign unused_wdt = ^{bus.wdt_en, bus.wdt_kick, 16'(WDT_LIMIT)};
  assign wdt_exp_c  = 1'b0;
`endif

  // Phase sequencing; any reset request forces a fresh HOLD with cleared counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + PHASE_W'(1);
    cause_d = cause_q;

    case (state_q)
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_REL0;
          cnt_d   = '0;
        end
      end
      ST_REL0: begin
        if (cnt_q == STAGE_LAST) begin
          state_d = ST_REL1;
          cnt_d   = '0;
        end
      end
      ST_REL1: begin
        if (cnt_q == STAGE_LAST) begin
          state_d = ST_REL2;
          cnt_d   = '0;
        end
      end
      ST_REL2: begin
        if (cnt_q == STAGE_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        cnt_d = '0;
      end
      default: begin
        state_d = ST_HOLD;
        cnt_d   = '0;
      end
    endcase

    // Watchdog expiry outranks a simultaneous software request.
    if (wdt_exp_c) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      cause_d = CAUSE_WDT;
    end else if (bus.swrst_req) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      cause_d = CAUSE_SW;
    end

    orst_d   = (state_d != ST_HOLD);
    rstmsk_d = dom_mask(state_d);
    busy_d   = (state_d != ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q  <= ST_HOLD;
      cnt_q    <= '0;
      cause_q  <= CAUSE_POR;
      orst_q   <= 1'b0;
      rstmsk_q <= '1;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cause_q  <= cause_d;
      orst_q   <= orst_d;
      rstmsk_q <= rstmsk_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.orst_     = orst_q;
  assign bus.rstmsk    = rstmsk_q;
  assign bus.rst_cause = cause_q;
  assign bus.busy      = busy_q;

endmodule

// File: doc/rst_seq_gen.md
RST_SEQ_GEN -- requirements
Module: rst_seq_gen

Interface
REQ-001 Parameter HOLD_CYC, default 16: cycles orst_ is held low per reset event (range 2..255).
REQ-002 Parameter STAGE_CYC, default 4: cycles between successive domain releases (range 1..255).
REQ-003 Parameter WDT_LIMIT, default 65535: watchdog terminal count (16-bit).
REQ-004 clk  in  1  single clock for all logic.
REQ-005 rst_  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-006 swrst_req  in  1  software reset request; level, sampled each cycle.
REQ-007 wdt_en  in  1  watchdog enable.
REQ-008 wdt_kick  in  1  watchdog restart pulse.
REQ-009 orst_  out  1  drives rst_ of the downstream 3-domain reset synchronizer array; 0 = reset.
REQ-010 rstmsk  out  3  drives the synchronizer array's mask; bit i = 1 holds domain i in reset.
REQ-011 rst_cause  out  2  last reset source: 0 POR, 1 SW, 2 WDT, 3 reserved.
REQ-012 busy  out  1  1 while any reset phase is in progress.

Function
REQ-013 FSM states: HOLD, REL0, REL1, REL2, RUN; all outputs registered.
REQ-014 HOLD: orst_=0, rstmsk=111, busy=1; cycle counter counts 0..HOLD_CYC-1, then moves to REL0 with orst_=1.
REQ-015 REL0: after STAGE_CYC cycles clear rstmsk[0], go REL1; REL1 clears rstmsk[1] after STAGE_CYC, go REL2; REL2 clears rstmsk[2] after STAGE_CYC, go RUN.
REQ-016 RUN: orst_=1, rstmsk=000, busy=0.
REQ-017 swrst_req=1 sampled in RUN at cycle t: at t+1 state=HOLD, counter=0, orst_=0, rstmsk=111, rst_cause=1.
REQ-018 swrst_req=1 in REL0..REL2: return to HOLD at next cycle, counter cleared, rstmsk=111, cause=1.
REQ-019 swrst_req=1 in HOLD: counter restarts at 0; cause updated to 1; hold extends.
REQ-020 swrst_req held high: HOLD persists; release sequence begins on first cycle it is low.
REQ-021 Watchdog counter (16-bit) increments each cycle in RUN when wdt_en=1; clears on wdt_kick, on wdt_en=0, or outside RUN.
REQ-022 Watchdog count reaching WDT_LIMIT: next cycle enters HOLD with cause=2; counter clears.
REQ-023 Simultaneous swrst_req and watchdog expiry: cause=2 (WDT has priority); single HOLD entry.
REQ-024 wdt_kick in the same cycle as expiry: kick wins, no reset.
REQ-025 Stage counter saturates never; it is cleared on every state transition.

Reset
REQ-026 rst_=0: state=HOLD, counters=0, orst_=0, rstmsk=111, busy=1, rst_cause=0.
REQ-027 rst_=0 mid-operation overrides all requests and restarts the full sequence from HOLD with cause=0.

Configuration
REQ-028 Macro RST_SEQ_GEN_WDT_EN defined: watchdog per REQ-021..REQ-024 present.
REQ-029 Macro undefined: watchdog logic absent, wdt_en/wdt_kick ports kept but ignored, rst_cause never 2.

Structure
REQ-030 Shared package rst_pkg holds the FSM state enum and rst_cause encodings (CAUSE_POR, CAUSE_SW, CAUSE_WDT).
REQ-031 Sub-module rst_wdt_cnt (watchdog counter, expiry pulse); instantiated only under RST_SEQ_GEN_WDT_EN.
REQ-032 Single flat FSM plus shared 8-bit phase counter in rst_seq_gen; no other sub-modules.

Verification
REQ-033 rst_ low 3 cycles then high, defaults -> orst_ rises 16 cycles after rst_ rise; rstmsk 111->110->100->000 at +4,+8,+12 cycles after that; busy falls with rstmsk=000; cause=0.
REQ-034 swrst_req 1-cycle pulse in RUN -> next cycle orst_=0, rstmsk=111, cause=1; full sequence repeats (16+12 cycles).
REQ-035 swrst_req pulse while in REL1 (rstmsk=100 pending) -> rstmsk returns to 111, HOLD counter restarts, 16 more cycles of orst_=0.
REQ-036 WDT_EN build, WDT_LIMIT=100, wdt_en=1, no kick -> HOLD entered 101 cycles after RUN entry, cause=2; with kick every 50 cycles -> no reset over 1000 cycles.
REQ-037 Expiry coincident with swrst_req -> single HOLD entry, cause=2; expiry coincident with wdt_kick -> no reset.
REQ-038 Build without RST_SEQ_GEN_WDT_EN, wdt_en=1, 70000 cycles without kick -> no reset, cause never 2.
